// File: rtl/vend_sequencer.sv
// Purpose: multi-product vending controller: coin credit, price check, dispense handshake, change/refund.
// Latency: every output is registered; a response appears in the cycle after the input that caused it.
// Backpressure: no input stalls; disp_req is held until disp_ack; coins that cannot be taken are bounced on coin_reject.
//
// Ports:
//   clk, reset_n                   clock (rising edge) and asynchronous active-low reset
//   coin[1:0]                      coin pulse: 01 = 1 unit, 10 = 2 units, 11 = invalid
//   sel_valid, sel[1:0]            product selection strobe and index
//   cancel                         refund request
//   disp_ack                       motor done (level, only looked at while dispensing)
//   disp_req, disp_id[1:0]         dispense request and product index
//   change_pulse                   one pulse per 1-unit coin paid back
//   coin_reject, sel_short         1-cycle notification pulses
//   credit[CREDIT_W-1:0]           current credit in units
//   busy                           high while dispensing or paying change
//   fault                          sticky motor-timeout flag
module vend_sequencer #(
    parameter int CREDIT_W     = 4,
    parameter int MAX_CREDIT   = 12,
    parameter int PRICE0       = 2,
    parameter int PRICE1       = 3,
    parameter int PRICE2       = 4,
    parameter int PRICE3       = 6,
    parameter int IDLE_TIMEOUT = 1000,
    parameter int ACK_TIMEOUT  = 200
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [1:0]          sel,
    input  logic                cancel,
    input  logic                disp_ack,
    output logic                disp_req,
    output logic [1:0]          disp_id,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                sel_short,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                fault
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit_n;
    logic                disp_req_n;
    logic [1:0]          disp_id_n;
    logic                change_pulse_n;
    logic                coin_reject_n;
    logic                sel_short_n;
    logic                busy_n;
    logic                fault_n;
    logic [IDLE_W-1:0]   idle_cnt, idle_cnt_n;
    logic [ACK_W-1:0]    ack_cnt, ack_cnt_n;

    logic [CREDIT_W-1:0] coin_units;
    logic                coin_present;
    logic                coin_ok;
    logic [CREDIT_W-1:0] price_sel;
    logic [CREDIT_W-1:0] price_cur;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] idx);
        logic [CREDIT_W-1:0] p;
        unique case (idx)
            2'd0: p = CREDIT_W'(PRICE0);
            2'd1: p = CREDIT_W'(PRICE1);
            2'd2: p = CREDIT_W'(PRICE2);
            2'd3: p = CREDIT_W'(PRICE3);
        endcase
        return p;
    endfunction

    // Coin decode and ceiling test; the sum is widened one bit so it cannot wrap.
    always_comb begin
        coin_units = '0;
        case (coin)
            2'b01:   coin_units = CREDIT_W'(1);
            2'b10:   coin_units = CREDIT_W'(2);
            default: coin_units = '0;
        endcase
        coin_present = (coin != 2'b00);
        coin_ok      = (coin != 2'b11) &&
                       (({1'b0, credit} + {1'b0, coin_units}) <= (CREDIT_W + 1)'(MAX_CREDIT));
        price_sel    = price_of(sel);
        price_cur    = price_of(disp_id);
    end

    always_comb begin
        state_n        = state;
        credit_n       = credit;
        disp_req_n     = disp_req;
        disp_id_n      = disp_id;
        change_pulse_n = 1'b0;
        coin_reject_n  = 1'b0;
        sel_short_n    = 1'b0;
        fault_n        = fault;
        idle_cnt_n     = idle_cnt;
        ack_cnt_n      = ack_cnt;

        unique case (state)
            ST_IDLE: begin
                idle_cnt_n = '0;
                ack_cnt_n  = '0;
                // Credit is zero here, so every product is unaffordable.
                if (sel_valid) begin
                    sel_short_n = 1'b1;
                end
                if (coin_present) begin
                    if (coin_ok) begin
                        credit_n = credit + coin_units;
                        state_n  = ST_CREDIT;
                    end else begin
                        coin_reject_n = 1'b1;
                    end
                end
            end

            ST_CREDIT: begin
                if (cancel) begin
                    state_n       = ST_CHANGE;
                    coin_reject_n = coin_present;
                end else if (sel_valid && (credit >= price_sel)) begin
                    // Price check uses the credit before any same-cycle coin.
                    credit_n      = credit - price_sel;
                    disp_id_n     = sel;
                    disp_req_n    = 1'b1;
                    ack_cnt_n     = '0;
                    state_n       = ST_DISPENSE;
                    coin_reject_n = coin_present;
                end else begin
                    // A refused selection does not block a same-cycle coin.
                    if (sel_valid) begin
                        sel_short_n = 1'b1;
                    end
                    if (coin_present) begin
                        if (coin_ok) begin
                            credit_n = credit + coin_units;
                        end else begin
                            coin_reject_n = 1'b1;
                        end
                    end
                    if (sel_valid || (coin_present && coin_ok)) begin
                        idle_cnt_n = '0;
                    end else if (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                        state_n = ST_CHANGE;
                    end else begin
                        idle_cnt_n = idle_cnt + IDLE_W'(1);
                    end
                end
            end

            ST_DISPENSE: begin
                coin_reject_n = coin_present;
                if (disp_ack) begin
                    disp_req_n = 1'b0;
                    state_n    = (credit != '0) ? ST_CHANGE : ST_IDLE;
                end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                    // Motor never answered: give the money back and latch the fault.
                    disp_req_n = 1'b0;
                    credit_n   = credit + price_cur;
                    fault_n    = 1'b1;
                    state_n    = ST_CHANGE;
                end else begin
                    ack_cnt_n = ack_cnt + ACK_W'(1);
                end
            end

            ST_CHANGE: begin
                coin_reject_n = coin_present;
                // Pulse high one cycle, low the next; credit drops with each high cycle.
                if (change_pulse) begin
                    if (credit == '0) begin
                        state_n = ST_IDLE;
                    end
                end else if (credit != '0) begin
                    change_pulse_n = 1'b1;
                    credit_n       = credit - CREDIT_W'(1);
                end else begin
                    state_n = ST_IDLE;
                end
            end
        endcase

        busy_n = (state_n == ST_DISPENSE) || (state_n == ST_CHANGE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            credit       <= '0;
            disp_req     <= 1'b0;
            disp_id      <= 2'd0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            sel_short    <= 1'b0;
            busy         <= 1'b0;
            fault        <= 1'b0;
            idle_cnt     <= '0;
            ack_cnt      <= '0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            disp_req     <= disp_req_n;
            disp_id      <= disp_id_n;
            change_pulse <= change_pulse_n;
            coin_reject  <= coin_reject_n;
            sel_short    <= sel_short_n;
            busy         <= busy_n;
            fault        <= fault_n;
            idle_cnt     <= idle_cnt_n;
            ack_cnt      <= ack_cnt_n;
        end
    end

    // Every route into CHANGE carries non-zero credit.
    a_change_has_credit: assert property (@(posedge clk) disable iff (!reset_n)
        ((state != ST_CHANGE) && (state_n == ST_CHANGE)) |-> (credit_n != '0));

    a_credit_ceiling: assert property (@(posedge clk) disable iff (!reset_n)
        credit <= CREDIT_W'(MAX_CREDIT));

endmodule

// File: tb/tb_vend_sequencer.sv
module tb_vend_sequencer;

    localparam int ACK_TIMEOUT  = 200;
    localparam int IDLE_TIMEOUT = 1000;

    localparam int EV_REJ   = 0;
    localparam int EV_SHORT = 1;
    localparam int EV_DISP  = 2;
    localparam int EV_DROP  = 3;
    localparam int EV_PULSE = 4;

    typedef struct {
        int kind;
        int id;
        int cr;
        int flt;
    } evt_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel = 2'b00;
    logic       cancel = 1'b0;
    logic       disp_ack = 1'b0;
    logic       disp_req;
    logic [1:0] disp_id;
    logic       change_pulse;
    logic       coin_reject;
    logic       sel_short;
    logic [3:0] credit;
    logic       busy;
    logic       fault;

    int   checks = 0;
    int   errors = 0;
    evt_t exp_q[$];
    logic prev_req = 1'b0;
    logic prev_pulse = 1'b0;

    vend_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .coin         (coin),
        .sel_valid    (sel_valid),
        .sel          (sel),
        .cancel       (cancel),
        .disp_ack     (disp_ack),
        .disp_req     (disp_req),
        .disp_id      (disp_id),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .sel_short    (sel_short),
        .credit       (credit),
        .busy         (busy),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    function automatic string kname(input int k);
        case (k)
            EV_REJ:   return "coin_reject";
            EV_SHORT: return "sel_short";
            EV_DISP:  return "disp_start";
            EV_DROP:  return "disp_end";
            default:  return "change_pulse";
        endcase
    endfunction

    task automatic push(input int k, input int id, input int cr, input int flt);
        evt_t e;
        e.kind = k;
        e.id   = id;
        e.cr   = cr;
        e.flt  = flt;
        exp_q.push_back(e);
    endtask

    task automatic match(input int k, input int id, input int cr, input int flt);
        evt_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event id=%0d credit=%0d fault=%0d, none expected",
                     kname(k), id, cr, flt);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.id != id || e.cr != cr || e.flt != flt) begin
                errors++;
                $display("FAIL %s: got %s id=%0d credit=%0d fault=%0d, expected %s id=%0d credit=%0d fault=%0d",
                         kname(e.kind), kname(k), id, cr, flt, kname(e.kind), e.id, e.cr, e.flt);
            end
        end
    endtask

    // Monitor: samples on the falling edge, pops one expectation per observed event.
    always @(negedge clk) begin
        if (reset_n) begin
            if (coin_reject)
                match(EV_REJ, 0, int'(credit), 0);
            if (sel_short)
                match(EV_SHORT, 0, int'(credit), 0);
            if (disp_req && !prev_req)
                match(EV_DISP, int'(disp_id), int'(credit), 0);
            if (!disp_req && prev_req)
                match(EV_DROP, 0, int'(credit), int'(fault));
            if (change_pulse) begin
                match(EV_PULSE, 0, int'(credit), 0);
                checks++;
                if (prev_pulse) begin
                    errors++;
                    $display("FAIL pulse_gap: got change_pulse high two cycles running, expected a low cycle between");
                end
            end
        end
        prev_req   = disp_req;
        prev_pulse = change_pulse;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] c, input logic sv, input logic [1:0] s, input logic cn);
        coin      = c;
        sel_valid = sv;
        sel       = s;
        cancel    = cn;
        step();
        coin      = 2'b00;
        sel_valid = 1'b0;
        cancel    = 1'b0;
    endtask

    task automatic wait_busy(input string name, input logic level, input int budget);
        int n;
        n = 0;
        while (busy !== level && n < budget) begin
            step();
            n++;
        end
        chk(name, int'(busy), int'(level));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        #3;
        chk("reset_outputs", int'({disp_req, disp_id, change_pulse, coin_reject, sel_short, credit, busy, fault}), 0);
        #19;
        reset_n = 1'b1;
        step();
        chk("idle_credit", int'(credit), 0);
        chk("idle_busy", int'(busy), 0);

        // Invalid coin in IDLE bounces; cancel in IDLE does nothing
        push(EV_REJ, 0, 0, 0);
        drive(2'b11, 1'b0, 2'd0, 1'b0);
        drive(2'b00, 1'b0, 2'd0, 1'b1);
        chk("idle_cancel_busy", int'(busy), 0);

        // 1) exact payment, no change
        drive(2'b01, 1'b0, 2'd0, 1'b0);
        chk("t1_credit1", int'(credit), 1);
        drive(2'b01, 1'b0, 2'd0, 1'b0);
        drive(2'b10, 1'b0, 2'd0, 1'b0);
        chk("t1_credit4", int'(credit), 4);
        push(EV_DISP, 2, 0, 0);
        drive(2'b00, 1'b1, 2'd2, 1'b0);
        chk("t1_disp_req", int'(disp_req), 1);
        chk("t1_busy", int'(busy), 1);
        push(EV_REJ, 0, 0, 0);
        drive(2'b01, 1'b0, 2'd0, 1'b0);
        drive(2'b00, 1'b1, 2'd1, 1'b0);
        step();
        chk("t1_disp_id_stable", int'(disp_id), 2);
        chk("t1_credit_dispense", int'(credit), 0);
        push(EV_DROP, 0, 0, 0);
        disp_ack = 1'b1;
        step();
        disp_ack = 1'b0;
        chk("t1_req_dropped", int'(disp_req), 0);
        chk("t1_idle", int'(busy), 0);
        repeat (4) step();

        // 2) one unit of change
        drive(2'b10, 1'b0, 2'd0, 1'b0);
        drive(2'b10, 1'b0, 2'd0, 1'b0);
        push(EV_DISP, 1, 1, 0);
        drive(2'b00, 1'b1, 2'd1, 1'b0);
        chk("t2_credit1", int'(credit), 1);
        push(EV_DROP, 0, 1, 0);
        push(EV_PULSE, 0, 0, 0);
        disp_ack = 1'b1;
        step();
        disp_ack = 1'b0;
        chk("t2_change_busy", int'(busy), 1);
        wait_busy("t2_back_idle", 1'b0, 20);
        chk("t2_credit0", int'(credit), 0);

        // 3) ceiling and full cancel refund
        repeat (5) drive(2'b10, 1'b0, 2'd0, 1'b0);
        drive(2'b01, 1'b0, 2'd0, 1'b0);
        chk("t3_credit11", int'(credit), 11);
        push(EV_REJ, 0, 11, 0);
        drive(2'b10, 1'b0, 2'd0, 1'b0);
        chk("t3_reject_keeps", int'(credit), 11);
        drive(2'b01, 1'b0, 2'd0, 1'b0);
        chk("t3_credit12", int'(credit), 12);
        for (int i = 11; i >= 0; i--) push(EV_PULSE, 0, i, 0);
        drive(2'b00, 1'b0, 2'd0, 1'b1);
        wait_busy("t3_back_idle", 1'b0, 40);
        chk("t3_credit0", int'(credit), 0);

        // 4) refused selection, same-cycle coin handling
        drive(2'b01, 1'b0, 2'd0, 1'b0);
        push(EV_SHORT, 0, 1, 0);
        drive(2'b00, 1'b1, 2'd0, 1'b0);
        chk("t4_short_credit", int'(credit), 1);
        push(EV_SHORT, 0, 2, 0);
        drive(2'b01, 1'b1, 2'd0, 1'b0);
        chk("t4_coin_after_short", int'(credit), 2);
        push(EV_REJ, 0, 0, 0);
        push(EV_DISP, 0, 0, 0);
        drive(2'b10, 1'b1, 2'd0, 1'b0);
        chk("t4_dispense", int'(disp_req), 1);
        push(EV_DROP, 0, 0, 0);
        disp_ack = 1'b1;
        step();
        disp_ack = 1'b0;
        wait_busy("t4_back_idle", 1'b0, 10);

        // 5) ack timeout: refund, fault, late ack ignored
        repeat (3) drive(2'b10, 1'b0, 2'd0, 1'b0);
        push(EV_DISP, 3, 0, 0);
        push(EV_DROP, 0, 6, 1);
        for (int i = 5; i >= 0; i--) push(EV_PULSE, 0, i, 0);
        drive(2'b00, 1'b1, 2'd3, 1'b0);
        n = 0;
        while (disp_req && n < ACK_TIMEOUT + 50) begin
            step();
            n++;
        end
        chk("t5_timeout_window", int'(n >= ACK_TIMEOUT && n <= ACK_TIMEOUT + 1), 1);
        chk("t5_fault", int'(fault), 1);
        chk("t5_refund", int'(credit), 6);
        disp_ack = 1'b1;
        wait_busy("t5_back_idle", 1'b0, 40);
        repeat (5) step();
        disp_ack = 1'b0;
        chk("t5_fault_sticky", int'(fault), 1);
        chk("t5_no_req", int'(disp_req), 0);
        chk("t5_credit0", int'(credit), 0);

        // Inactivity refund
        drive(2'b01, 1'b0, 2'd0, 1'b0);
        repeat (IDLE_TIMEOUT - 10) step();
        chk("idle_wait_busy", int'(busy), 0);
        chk("idle_wait_credit", int'(credit), 1);
        push(EV_PULSE, 0, 0, 0);
        wait_busy("idle_to_change", 1'b1, 30);
        wait_busy("idle_refund_done", 1'b0, 10);

        // 6) reset in the middle of CHANGE
        drive(2'b10, 1'b0, 2'd0, 1'b0);
        drive(2'b10, 1'b0, 2'd0, 1'b0);
        drive(2'b01, 1'b0, 2'd0, 1'b0);
        drive(2'b00, 1'b0, 2'd0, 1'b1);
        chk("t6_in_change", int'(busy), 1);
        chk("t6_credit5", int'(credit), 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_clear", int'({disp_req, disp_id, change_pulse, coin_reject, sel_short, credit, busy, fault}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("t6_idle_busy", int'(busy), 0);
        chk("t6_idle_credit", int'(credit), 0);
        drive(2'b01, 1'b0, 2'd0, 1'b0);
        chk("t6_coin_after_reset", int'(credit), 1);
        push(EV_PULSE, 0, 0, 0);
        drive(2'b00, 1'b0, 2'd0, 1'b1);
        wait_busy("t6_final_idle", 1'b0, 10);

        repeat (3) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
